// File: rtl/link_pkg.sv
// Constants and state encodings shared by the transmit and receive ends of the token-router serial link.
// Pure declarations: no logic, no latency, no flow control.
package link_pkg;

  localparam int PKT_W    = 55;
  localparam int IDLE_GAP = 8;
  localparam int CNT_W    = 7;

  localparam logic [5:0] PREAMBLE = 6'b011111;

  typedef enum logic [3:0] {
    TX_IDLE = 4'b0001,
    TX_PRE  = 4'b0010,
    TX_DATA = 4'b0100,
    TX_GAP  = 4'b1000
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_WAIT = 3'b001,
    RX_READ = 3'b010,
    RX_DONE = 3'b100
  } rx_state_t;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-out shift register; load wins over shift, MSB valid the cycle after load.
// No backpressure: the owner decides when to load and when to shift.
module piso_shift
  import link_pkg::*;
#(
  parameter int W = PKT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[W-1];

endmodule

// File: rtl/transmit_protocol.sv
// Serial framer: preamble, PKT_W payload bits MSB first, then IDLE_GAP high cycles; first bit one cycle after accept.
// send is taken only when !busy (no queue); all outputs registered, line idles high.
module transmit_protocol
  import link_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] packet,
  input  logic             send,
  output logic             S_Data,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'($bits(PREAMBLE) - 1);
  localparam logic [CNT_W-1:0] CNT_PKT_LAST = CNT_W'(PKT_W - 1);
  localparam logic [CNT_W-1:0] CNT_GAP_LAST = CNT_W'(IDLE_GAP - 1);

  tx_state_t        r_state;
  tx_state_t        w_nstate;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_ncnt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             r_sdata;
  logic             r_busy;
  logic             r_done;
  logic             w_nsdata;
  logic             w_ndone;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;

  piso_shift #(
    .W (PKT_W)
  ) u_piso (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (packet),
    .o_msb   (w_msb)
  );

  assign w_cnt_dec = r_cnt - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // Next-cycle line value is computed here and registered, so each state's
  // counter describes the bit currently on the wire.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nsdata = 1'b1;
    w_ndone  = 1'b0;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (send) begin
          w_nstate = TX_PRE;
          w_ncnt   = CNT_PRE_LAST;
          w_load   = 1'b1;
          w_nsdata = PREAMBLE[CNT_PRE_LAST[2:0]];
        end
      end
      TX_PRE: begin
        if (r_cnt == '0) begin
          w_nstate = TX_DATA;
          w_ncnt   = CNT_PKT_LAST;
          w_shift  = 1'b1;
          w_nsdata = w_msb;
        end else begin
          w_ncnt   = w_cnt_dec;
          w_nsdata = PREAMBLE[w_cnt_dec[2:0]];
        end
      end
      TX_DATA: begin
        if (r_cnt == '0) begin
          w_nstate = TX_GAP;
          w_ncnt   = CNT_GAP_LAST;
        end else begin
          w_ncnt   = w_cnt_dec;
          w_shift  = 1'b1;
          w_nsdata = w_msb;
        end
      end
      TX_GAP: begin
        if (r_cnt == '0) begin
          w_nstate = TX_IDLE;
          w_ndone  = 1'b1;
        end else begin
          w_ncnt   = w_cnt_dec;
        end
      end
      default: begin
        w_nstate = TX_IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_sdata <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cnt   <= w_ncnt;
      r_sdata <= w_nsdata;
      r_busy  <= (w_nstate != TX_IDLE);
      r_done  <= w_ndone;
    end
  end

  assign S_Data = r_sdata;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_transmit_protocol.sv
// Directed bench for transmit_protocol: reset, single frames, ignore-while-busy, mid-frame reset, back-to-back.
// Inputs driven and outputs sampled on the falling edge.
module tb_transmit_protocol;

  logic        clk = 1'b0;
  logic        rst;
  logic [54:0] packet;
  logic        send;
  logic        S_Data;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_bad = 0;

  logic [54:0] pk [0:214];
  logic        sl [0:215];
  logic        dn [0:215];

  always #5 clk = ~clk;

  transmit_protocol dut (
    .clk    (clk),
    .rst    (rst),
    .packet (packet),
    .send   (send),
    .S_Data (S_Data),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One frame accepted on the next rising edge; optionally pokes send mid-frame.
  task automatic run_frame(input logic [54:0] pkt, input bit poke);
    logic [68:0] cap;
    logic [68:0] bcap;
    logic [68:0] exp_line;
    int          dcnt;
    exp_line = {6'b011111, pkt, 8'hFF};
    send   = 1'b1;
    packet = pkt;
    @(negedge clk);
    send   = 1'b0;
    packet = ~pkt;
    dcnt   = 0;
    for (int i = 0; i < 69; i++) begin
      cap[68-i]  = S_Data;
      bcap[68-i] = busy;
      dcnt       = dcnt + int'(done);
      if (poke && i == 19) begin
        send   = 1'b1;
        packet = pkt ^ 55'h5A5A_A5A5_0F0F;
      end else if (poke && i == 20) begin
        send   = 1'b0;
      end
      @(negedge clk);
    end
    chk("frame_line", 80'(cap), 80'(exp_line));
    chk("frame_busy", 80'(bcap), 80'({69{1'b1}}));
    chk("frame_early_done", 80'(dcnt), 80'(0));
    chk("done_pulse", 80'(done), 80'(1));
    chk("busy_at_done", 80'(busy), 80'(0));
    chk("line_at_done", 80'(S_Data), 80'(1));
    @(negedge clk);
    chk("done_width", 80'(done), 80'(0));
  endtask

  initial begin
    logic        bad_seen;
    logic        busy_seen;
    logic [69:0] got70;
    logic [69:0] exp70;
    int          dcount;

    // Reset held with send high: nothing may start.
    rst    = 1'b0;
    send   = 1'b1;
    packet = 55'h7F_FFFF_FFFF_FFFF;
    bad_seen = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (S_Data !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_seen = 1'b1;
    end
    chk("reset_outputs", 80'(bad_seen), 80'(0));
    chk("reset_line", 80'(S_Data), 80'(1));
    send = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 80'(busy), 80'(0));
    chk("post_reset_done", 80'(done), 80'(0));

    run_frame(55'h2A_5555_0F0F_F0F1, 1'b0);
    run_frame({55{1'b1}}, 1'b0);
    run_frame(55'h0, 1'b0);
    run_frame(55'h1, 1'b0);

    // Ignore-while-busy, then confirm no second frame follows.
    run_frame(55'h35_1234_ABCD_0042, 1'b1);
    busy_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    chk("no_second_frame", 80'(busy_seen), 80'(0));

    // Mid-frame reset while the line is low (all-zero payload).
    send   = 1'b1;
    packet = 55'h0;
    @(negedge clk);
    send   = 1'b0;
    repeat (29) @(negedge clk);
    chk("line_low_before_rst", 80'(S_Data), 80'(0));
    rst = 1'b0;
    #1;
    chk("rst_line", 80'(S_Data), 80'(1));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_busy", 80'(busy), 80'(0));
    run_frame(55'h12_3456_789A_BCDE, 1'b0);

    // Back-to-back: send held 200 cycles, packet changing every cycle.
    sl[0] = S_Data;
    dn[0] = done;
    for (int c = 0; c < 215; c++) begin
      if (c < 200) begin
        send   = 1'b1;
        packet = {23'($urandom), $urandom};
      end else begin
        send   = 1'b0;
      end
      pk[c] = packet;
      @(negedge clk);
      sl[c+1] = S_Data;
      dn[c+1] = done;
    end
    send = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp70 = {6'b011111, pk[70*k], 9'h1FF};
      for (int j = 0; j < 70; j++) got70[69-j] = sl[70*k + 1 + j];
      chk($sformatf("b2b_frame%0d", k), 80'(got70), 80'(exp70));
      chk($sformatf("b2b_done%0d", k), 80'(dn[70*k + 70]), 80'(1));
    end
    dcount = 0;
    for (int c = 0; c <= 215; c++) dcount = dcount + int'(dn[c]);
    chk("b2b_done_count", 80'(dcount), 80'(3));
    chk("b2b_idle_after", 80'(busy), 80'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/transmit_protocol.md
# transmit_protocol

Serial framer for the token-router link, placed directly upstream of the serial receiver. Accepts a 55-bit packet over a valid/busy handshake and drives it onto the one-bit `S_Data` line. Each frame is a fixed 6-bit preamble (`0,1,1,1,1,1`), then 55 payload bits MSB first, then a mandatory idle gap of 1s so the downstream receiver re-arms its start detector. Line idles high.

## Interface
- `PKT_W`, 55, payload width in bits
- `PREAMBLE`, 6'b011111, start sequence, transmitted bit 5 first
- `IDLE_GAP`, 8, line-high cycles after each frame; minimum legal value 4
- `clk` input 1 single system clock; all state changes on rising edge
- `rst` input 1 reset, asynchronous, active-low
- `packet` input PKT_W payload to send; sampled only on acceptance
- `send` input 1 request; accepted when `send && !busy`
- `S_Data` output 1 serial line, registered; reset value 1
- `busy` output 1 high from the cycle after acceptance through the last gap cycle; reset value 0
- `done` output 1 one-cycle pulse when a frame, including its gap, completes; reset value 0

## Operation
- States: IDLE, PRE, DATA, GAP. One-hot encoding. Reset state is IDLE.
- IDLE: `S_Data`=1, `busy`=0. If `send`=1, latch `packet` into the shift register, set the bit counter to 5, and go to PRE.
- PRE: `S_Data`=`PREAMBLE[cnt]`. Decrement the counter each cycle. When the counter reaches 0, load `PKT_W-1` and go to DATA.
- DATA: `S_Data`=shreg MSB. Shift left by 1 each cycle. After `PKT_W` bits, load `IDLE_GAP-1` and go to GAP.
- GAP: `S_Data`=1. Count down. After `IDLE_GAP` cycles, go to IDLE and assert `done` for that one cycle.
- Counter is 7 bits. It must hold `max(PKT_W, IDLE_GAP)-1` without overflow, and it never wraps below 0.
- `send` asserted while `busy`=1 is ignored. There is no queue.
- Changes to `packet` after acceptance have no effect on the frame in flight.
- Payload bits equal to the preamble pattern are not escaped. The receiver is length-framed, so none is needed.
- Reset mid-frame: the frame is aborted immediately. `S_Data`=1, `busy`=0, `done`=0, state IDLE, shift register cleared. The receiver may hold a partial packet; this is accepted behaviour.

## Timing
- Acceptance at edge t. Preamble bits appear on `S_Data` at cycles t+1..t+6.
- Payload bit 54 appears at t+7 and bit 0 at t+61.
- Gap occupies t+62..t+61+IDLE_GAP.
- `busy` is 1 over t+1..t+61+IDLE_GAP.
- `done`=1 and `busy`=0 at cycle t+62+IDLE_GAP.
- Same-cycle case: if `send` is high on the `done` cycle, the next frame is accepted then. Its first preamble bit appears the following cycle.
- Back-to-back period is therefore 6+PKT_W+IDLE_GAP+1 = 70 cycles at defaults.
- `S_Data`, `busy` and `done` are all registered. There is no combinational path from `send` or `packet` to any output.

## Structure
- Shared package `link_pkg` holds the constants used by both sides of the link: `PKT_W`, `PREAMBLE`, `IDLE_GAP`, and the state encodings (IDLE/PRE/DATA/GAP and WAIT/READ/DONE).
- Natural sub-module: `piso_shift`, a PKT_W-bit parallel-load, MSB-out shift register with load/shift enables.
- The FSM and counters stay in `transmit_protocol`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `send`=1 -> `S_Data`=1, `busy`=0 and `done`=0 throughout. No frame starts until `rst` is released.
- Single frame: `packet`=55'h2A_5555_0F0F_F0F1 with a one-cycle `send` -> `S_Data` carries 0,1,1,1,1,1 then the packet MSB first, then 8 ones. `done` pulses at t+70.
- Loopback: connect to the serial receiver and send all-ones, all-zeros and 55'h1 -> the receiver's `ready` pulses once per frame and its `packet` equals the input each time.
- Back-to-back: hold `send`=1 for 200 cycles while `packet` changes each cycle -> frames start exactly 70 cycles apart. Each frame carries the value present on its acceptance cycle.
- Ignore while busy: pulse `send` at t+20 with a different packet -> no effect on the frame in flight. No second frame is sent.
- Mid-frame reset: assert `rst` at t+30 -> `S_Data`=1 immediately (asynchronous). After release, a new `send` produces a complete, correct frame.
